// File: rtl/jt900h_regs_pkg.sv
// jt900h_regs_pkg: shared constants for the TLCS-900H register file
package jt900h_regs_pkg;
  localparam logic [2:0] W_BYTE = 3'b001, W_WORD = 3'b010, W_LONG = 3'b100;
  typedef enum logic [1:0] {RFP_NONE, RFP_INCF, RFP_DECF, RFP_LDF} rfp_op_e;
  localparam logic [7:0] CODE_PREV = 8'hD0, CODE_CUR = 8'hE0, CODE_DED = 8'hF0;
endpackage

// File: rtl/jt900h_regdec.sv
// jt900h_regdec: full register code + width + RFP -> aligned byte index, byte mask, valid
module jt900h_regdec import jt900h_regs_pkg::*; (
  input  logic [7:0] code_i,
  input  logic [2:0] w_i,
  input  logic [1:0] rfp_i,
  output logic [6:0] idx_o,
  output logic [3:0] mask_o,
  output logic       valid_o
);
  logic [1:0] off, bank;
  always_comb begin
    off     = |(w_i & W_BYTE) ? code_i[1:0] : |(w_i & W_WORD) ? {code_i[1], 1'b0} : 2'b00;
    mask_o  = |(w_i & W_BYTE) ? 4'b0001 : |(w_i & W_WORD) ? 4'b0011 : 4'b1111;
    bank    = code_i[7:4] == CODE_PREV[7:4] ? rfp_i - 2'd1 :
              code_i[7:4] == CODE_CUR[7:4]  ? rfp_i : code_i[5:4];
    valid_o = code_i[7:6] == 2'b00 || code_i[7:4] >= CODE_PREV[7:4];
    // dedicated registers live after the four 16-byte banks
    idx_o   = code_i[7:4] == CODE_DED[7:4] ? {3'b100, code_i[3:2], off} : {1'b0, bank, code_i[3:2], off};
  end
endmodule

// File: rtl/jt900h_regs.sv
// jt900h_regs: TLCS-900H banked register file with RFP, registered read ports and write forwarding
module jt900h_regs import jt900h_regs_pkg::*; #(
  parameter logic [31:0] XSP_RST = 32'h100,
  parameter bit          FWD     = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cen,
  input  logic [7:0]  rd0_code,
  input  logic [7:0]  rd1_code,
  input  logic [2:0]  rd_w,
  input  logic        we,
  input  logic [7:0]  wr_code,
  input  logic [2:0]  wr_w,
  input  logic [31:0] din,
  input  logic [1:0]  rfp_op,
  input  logic [1:0]  rfp_din,
  output logic [31:0] op0,
  output logic [31:0] op1,
  output logic [1:0]  rfp,
  output logic        bad_code
);
  logic [7:0]  mem_q [80];
  logic [1:0]  rfp_q, rfp_d;
  logic [31:0] op0_q, op1_q;
  logic        bad_q, bad_d;
  logic [6:0]  ri [2];
  logic [3:0]  rm [2];
  logic        rv [2];
  logic [31:0] rd [2];
  logic [6:0]  wi, a;
  logic [3:0]  wm;
  logic        wv;
  logic [7:0]  b;

  jt900h_regdec u_rd0 (.code_i(rd0_code), .w_i(rd_w), .rfp_i(rfp_q), .idx_o(ri[0]), .mask_o(rm[0]), .valid_o(rv[0]));
  jt900h_regdec u_rd1 (.code_i(rd1_code), .w_i(rd_w), .rfp_i(rfp_q), .idx_o(ri[1]), .mask_o(rm[1]), .valid_o(rv[1]));
  jt900h_regdec u_wr  (.code_i(wr_code),  .w_i(wr_w), .rfp_i(rfp_q), .idx_o(wi),    .mask_o(wm),    .valid_o(wv));

  // byte-granular merge: each read byte may be replaced by the byte being written this cycle
  always_comb begin
    a = '0;
    b = '0;
    rd[0] = '0;
    rd[1] = '0;
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < 4; k++)
        if (rv[p] && rm[p][k]) begin
          a = ri[p] + 7'(k);
          b = mem_q[a];
          for (int j = 0; j < 4; j++)
            if (FWD && we && wv && wm[j] && wi + 7'(j) == a) b = din[8*j +: 8];
          rd[p][8*k +: 8] = b;
        end
    rfp_d = rfp_op == RFP_INCF ? rfp_q + 2'd1 :
            rfp_op == RFP_DECF ? rfp_q - 2'd1 :
            rfp_op == RFP_LDF  ? rfp_din : rfp_q;
    bad_d = !rv[0] || !rv[1] || (we && !wv);
  end

  always_ff @(posedge clk)
    if (rst) begin
      for (int i = 0; i < 76; i++) mem_q[i] <= '0;
      for (int i = 0; i < 4; i++) mem_q[76+i] <= XSP_RST[8*i +: 8];
      rfp_q <= '0;
      op0_q <= '0;
      op1_q <= '0;
      bad_q <= 1'b0;
    end else if (cen) begin
      if (we && wv)
        for (int j = 0; j < 4; j++)
          if (wm[j]) mem_q[wi + 7'(j)] <= din[8*j +: 8];
      rfp_q <= rfp_d;
      op0_q <= rd[0];
      op1_q <= rd[1];
      bad_q <= bad_d;
    end

  assign op0      = op0_q;
  assign op1      = op1_q;
  assign rfp      = rfp_q;
  assign bad_code = bad_q;
endmodule

// File: tb/tb_jt900h_regs.sv
// tb_jt900h_regs: directed spec scenarios plus randomized traffic against a byte-array reference model
module tb_jt900h_regs;
  logic        clk = 1'b0, rst = 1'b1, cen = 1'b1, we = 1'b0;
  logic [7:0]  rd0_code = '0, rd1_code = '0, wr_code = '0;
  logic [2:0]  rd_w = 3'b100, wr_w = 3'b100;
  logic [31:0] din = '0;
  logic [1:0]  rfp_op = '0, rfp_din = '0;
  logic [31:0] op0, op1;
  logic [1:0]  rfp;
  logic        bad_code;

  logic [7:0]  m_mem [80];
  int          m_rfp;
  logic [31:0] m_op0, m_op1;
  logic        m_bad;
  int          total = 0, passes = 0;

  jt900h_regs #(.XSP_RST(32'h100), .FWD(1'b1)) dut (
    .clk(clk), .rst(rst), .cen(cen), .rd0_code(rd0_code), .rd1_code(rd1_code), .rd_w(rd_w),
    .we(we), .wr_code(wr_code), .wr_w(wr_w), .din(din), .rfp_op(rfp_op), .rfp_din(rfp_din),
    .op0(op0), .op1(op1), .rfp(rfp), .bad_code(bad_code)
  );

  always #5 clk = ~clk;

  function automatic int nbytes(input logic [2:0] w);
    return w[0] ? 1 : w[1] ? 2 : 4;
  endfunction

  function automatic int addr(input logic [7:0] c, input logic [2:0] w);
    int n = nbytes(w);
    int base;
    if (c < 8'h40) base = int'(c) / 16 * 16;
    else if (c < 8'hD0) return -1;
    else if (c < 8'hE0) base = ((m_rfp + 3) % 4) * 16;
    else if (c < 8'hF0) base = m_rfp * 16;
    else base = 64;
    return base + (int'(c) % 16) / n * n;
  endfunction

  function automatic logic [31:0] mread(input logic [7:0] c);
    int ra = addr(c, rd_w);
    int wa = addr(wr_code, wr_w);
    logic [31:0] r = '0;
    if (ra < 0) return '0;
    for (int k = 0; k < nbytes(rd_w); k++) begin
      r[8*k +: 8] = m_mem[ra+k];
      if (we && wa >= 0 && ra + k >= wa && ra + k < wa + nbytes(wr_w)) r[8*k +: 8] = din[8*(ra+k-wa) +: 8];
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passes++;
    else $error("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic tick();
    int wa;
    if (rst) begin
      foreach (m_mem[i]) m_mem[i] = '0;
      m_mem[77] = 8'h01;
      m_rfp = 0;
      m_op0 = '0;
      m_op1 = '0;
      m_bad = 1'b0;
    end else if (cen) begin
      m_op0 = mread(rd0_code);
      m_op1 = mread(rd1_code);
      wa = addr(wr_code, wr_w);
      m_bad = addr(rd0_code, rd_w) < 0 || addr(rd1_code, rd_w) < 0 || (we && wa < 0);
      if (we && wa >= 0)
        for (int k = 0; k < nbytes(wr_w); k++) m_mem[wa+k] = din[8*k +: 8];
      case (rfp_op)
        2'b01: m_rfp = (m_rfp + 1) % 4;
        2'b10: m_rfp = (m_rfp + 3) % 4;
        2'b11: m_rfp = int'(rfp_din);
        default: ;
      endcase
    end
    @(posedge clk);
    #1;
    chk("op0", op0, m_op0);
    chk("op1", op1, m_op1);
    chk("rfp", 32'(rfp), 32'(m_rfp));
    chk("bad_code", 32'(bad_code), 32'(m_bad));
  endtask

  task automatic rd(input logic [7:0] c0, input logic [7:0] c1, input logic [2:0] w);
    rd0_code = c0; rd1_code = c1; rd_w = w;
  endtask

  task automatic wr(input logic e, input logic [7:0] c, input logic [2:0] w, input logic [31:0] d);
    we = e; wr_code = c; wr_w = w; din = d;
  endtask

  initial begin
    tick();
    rst = 1'b0;
    rd(8'hFC, 8'hE0, 3'b100); tick();
    chk("xsp_reset", op0, 32'h100);
    chk("e0_reset", op1, 32'h0);
    chk("rfp_reset", 32'(rfp), 32'd0);
    rfp_op = 2'b11; rfp_din = 2'd2; tick(); rfp_op = 2'b00;
    chk("ldf2", 32'(rfp), 32'd2);
    wr(1, 8'hE4, 3'b100, 32'h11223344); tick(); wr(0, 0, 3'b100, 0);
    rd(8'h24, 8'h24, 3'b100); tick();
    chk("bank_long", op0, 32'h11223344);
    rd(8'hE5, 8'hE5, 3'b001); tick();
    chk("bank_byte", op0, 32'h33);
    wr(1, 8'hE8, 3'b010, 32'hBEEF); tick();
    wr(1, 8'hE9, 3'b001, 32'h12); tick(); wr(0, 0, 3'b100, 0);
    rd(8'hE8, 8'hE8, 3'b100); tick();
    chk("width_merge", op0, 32'h000012EF);
    rfp_op = 2'b11; rfp_din = 2'd0; tick();
    rfp_op = 2'b10; tick();
    chk("decf_wrap", 32'(rfp), 32'd3);
    rfp_op = 2'b01; tick();
    chk("incf_wrap", 32'(rfp), 32'd0);
    rfp_op = 2'b11; rfp_din = 2'd1; tick(); rfp_op = 2'b00;
    wr(1, 8'hD0, 3'b001, 32'h5A); tick(); wr(0, 0, 3'b100, 0);
    rd(8'h00, 8'h00, 3'b001); tick();
    chk("prev_bank", op0, 32'h5A);
    rfp_op = 2'b01; wr(1, 8'hE0, 3'b100, 32'h77); tick(); rfp_op = 2'b00; wr(0, 0, 3'b100, 0);
    rd(8'h10, 8'hE0, 3'b100); tick();
    chk("old_bank_wr", op0, 32'h77);
    chk("new_bank_clean", op1, 32'h0);
    rd(8'hE2, 8'hE2, 3'b010); wr(1, 8'hE0, 3'b100, 32'hCAFEF00D); tick(); wr(0, 0, 3'b100, 0);
    chk("forward", op0, 32'hCAFE);
    rd(8'hE3, 8'hE3, 3'b100); tick();
    chk("misaligned", op0, 32'hCAFEF00D);
    rd(8'h80, 8'h00, 3'b100); tick();
    chk("unmapped_rd", op0, 32'h0);
    chk("bad_set", 32'(bad_code), 32'd1);
    rd(8'h00, 8'h00, 3'b001); tick();
    chk("bad_clear", 32'(bad_code), 32'd0);
    cen = 1'b0; rd(8'hE0, 8'hE0, 3'b100); wr(1, 8'hE0, 3'b100, 32'h0); tick();
    chk("cen_hold", op0, 32'h5A);
    cen = 1'b1; wr(0, 0, 3'b100, 0); tick();
    chk("cen_nowrite", op0, 32'hCAFEF00D);
    rst = 1'b1; wr(1, 8'hE0, 3'b100, 32'hFFFFFFFF); tick();
    rst = 1'b0; wr(0, 0, 3'b100, 0); rd(8'h00, 8'h20, 3'b100); tick();
    chk("rst_discard", op0, 32'h0);
    for (int i = 0; i < 400; i++) begin
      rst = $urandom_range(0, 63) == 0;
      cen = $urandom_range(0, 9) != 0;
      rd0_code = 8'($urandom); rd1_code = $urandom_range(0, 1) ? 8'($urandom) : rd0_code;
      rd_w = $urandom_range(0, 1) ? 3'(1 << $urandom_range(0, 2)) : 3'($urandom);
      we = 1'($urandom);
      wr_code = $urandom_range(0, 1) ? {2'b11, 6'($urandom)} : 8'($urandom);
      wr_w = $urandom_range(0, 1) ? 3'(1 << $urandom_range(0, 2)) : 3'($urandom);
      din = $urandom;
      rfp_op = 2'($urandom); rfp_din = 2'($urandom);
      tick();
    end
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
